// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side consumer for a synchronous FIFO with one-cycle read latency.
//   Issues rd_en against a 2-entry credit budget and presents returned
//   words as a valid/ready stream through a 2-entry skid buffer, so the
//   stream keeps one beat per cycle under steady flow and loses nothing
//   under backpressure.
//
// Ports
//   clk            rising-edge clock shared with the FIFO
//   rst_n          asynchronous active-low reset
//   fifo_empty     FIFO empty flag
//   fifo_data_out  FIFO read data, valid the cycle after rd_en is sampled
//   fifo_underflow FIFO underflow flag, meaningful in the data-return cycle
//   rd_en          FIFO read request (combinational)
//   m_valid        downstream data valid
//   m_data         downstream data (head of the skid buffer)
//   m_ready        downstream ready
//   beat_count     number of accepted downstream beats, wrapping
//   err_underflow  sticky underflow error, cleared only by reset
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  err_underflow
);

  logic [1:0]            occ;
  logic                  inflight;
  logic [FIFO_WIDTH-1:0] buf_head;
  logic [FIFO_WIDTH-1:0] buf_tail;

  logic                  pop;
  logic                  push;
  logic [2:0]            credit_used;

  assign pop  = m_valid && m_ready;
  assign push = inflight && !fifo_underflow;

  // Slots committed after this edge: stored words plus the word returning
  // now, minus the word leaving now. A new read is only issued while that
  // total leaves room, which keeps occ + inflight <= 2 at every edge.
  assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // rst_n gates rd_en so the FIFO is never read while this block is held
  // in reset.
  assign rd_en = rst_n && !fifo_empty && (credit_used < 3'd2);

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ           <= 2'd0;
      inflight      <= 1'b0;
      buf_head      <= '0;
      buf_tail      <= '0;
      beat_count    <= '0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= rd_en;

      if (pop) begin
        beat_count <= beat_count + 1'b1;
      end

      // A flagged return carries no data: drop it and latch the error.
      if (inflight && fifo_underflow) begin
        err_underflow <= 1'b1;
      end

      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            buf_head <= fifo_data_out;
          end else begin
            buf_tail <= fifo_data_out;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf_head <= buf_tail;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          // Head leaves and the new word joins at the back; occ unchanged.
          if (occ == 2'd1) begin
            buf_head <= fifo_data_out;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= fifo_data_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
